// File: rtl/scaler_pkg.sv
// Shared definitions for the horizontal and vertical scaler blocks.
package scaler_pkg;

  localparam int unsigned SCALER_V_LATENCY = 4;
  localparam int unsigned STEP_W           = 16;

  typedef enum logic [1:0] {
    BLANK,
    LINE_WAIT,
    LINE_RUN
  } vctl_state_e;

  // Fractional bit count of a power-of-two fixed-point unit.
  function automatic int unsigned frac_w(input int unsigned pixel_step);
    return $clog2(pixel_step);
  endfunction

endpackage

// File: rtl/scaler_v_linebuf.sv
// Previous-line store: simple dual-port RAM with a registered,
// read-before-write read port.
module scaler_v_linebuf #(
  parameter int unsigned DEPTH  = 4096,
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    rdata_q <= mem_q[raddr_i];
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/scaler_v.sv
// Vertical down-scaler: blends the stored previous line with the live line,
// one output pixel per input pixel, fixed latency.
module scaler_v
  import scaler_pkg::*;
#(
  parameter int unsigned PIXEL_WIDTH   = 8,
  parameter int unsigned PIXEL_STEP    = 32,
  parameter int unsigned COE_WIDTH     = 8,
  parameter int unsigned LINE_SIZE_MAX = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [STEP_W-1:0]      scale_step_v,
  input  logic [PIXEL_WIDTH-1:0] di_i,
  input  logic                   de_i,
  input  logic                   hs_i,
  input  logic                   vs_i,
  output logic [PIXEL_WIDTH-1:0] do_o,
  output logic                   de_o,
  output logic                   hs_o,
  output logic                   vs_o
);

  localparam int unsigned FRAC_W = frac_w(PIXEL_STEP);
  localparam int unsigned INT_W  = 12;
  localparam int unsigned POS_W  = INT_W + FRAC_W;
  localparam int unsigned ADDR_W = $clog2(LINE_SIZE_MAX);
  localparam int unsigned X_W    = ADDR_W + 1;
  localparam int unsigned PROD_W = PIXEL_WIDTH + COE_WIDTH + 1;
  localparam int unsigned CSH    = COE_WIDTH - FRAC_W;
  localparam int unsigned LAT    = SCALER_V_LATENCY;

  vctl_state_e            state_q, state_d;
  logic [INT_W-1:0]       line_q, line_d;
  logic [POS_W-1:0]       pos_q, pos_d;
  logic [STEP_W-1:0]      step_q, step_d;
  logic                   active_q, active_d;
  logic [X_W-1:0]         x_q, x_d, x_eff;
  logic                   pix_ok;
  logic [COE_WIDTH-1:0]   coe_c;
  logic [PIXEL_WIDTH-1:0] prev_c;

  logic [LAT-1:0]         de_q, hs_q, vs_q;
  logic [PIXEL_WIDTH-1:0] cur1_q, cur2_q;
  logic [COE_WIDTH-1:0]   coe1_q, coe2_q;
  logic [PROD_W-1:0]      mp2_q, mp3_q, mc3_q, sum4_q;

  // Output line m sits at m*step; it is emitted while input line n = int(pos)+1 streams.
  function automatic logic line_hit(input logic [INT_W-1:0] n, input logic [POS_W-1:0] p);
    return (n != '0) && (p[POS_W-1:FRAC_W] == n - INT_W'(1));
  endfunction

  always_comb begin
    state_d  = state_q;
    line_d   = line_q;
    pos_d    = pos_q;
    step_d   = step_q;
    active_d = active_q;
    if (vs_i) begin
      state_d  = LINE_WAIT;
      line_d   = '0;
      pos_d    = '0;
      active_d = 1'b0;
      step_d   = (scale_step_v < STEP_W'(PIXEL_STEP)) ? STEP_W'(PIXEL_STEP) : scale_step_v;
    end else if (hs_i) begin
      case (state_q)
        LINE_WAIT: begin
          state_d  = LINE_RUN;
          active_d = line_hit(line_q, pos_q);
        end
        LINE_RUN: begin
          line_d = line_q + INT_W'(1);
          if (active_q) pos_d = pos_q + POS_W'(step_q);
          active_d = line_hit(line_d, pos_d);
        end
        default: ;
      endcase
    end
  end

  // hs_i wins over a coincident de_i, so that pixel lands at x=0 of the new line.
  always_comb begin
    x_eff  = hs_i ? '0 : x_q;
    pix_ok = de_i && (state_d == LINE_RUN) && (x_eff < X_W'(LINE_SIZE_MAX));
    x_d    = x_eff;
    if (pix_ok) x_d = x_eff + X_W'(1);
    coe_c  = COE_WIDTH'(pos_d[FRAC_W-1:0]) << CSH;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= BLANK;
      line_q   <= '0;
      pos_q    <= '0;
      step_q   <= STEP_W'(PIXEL_STEP);
      active_q <= 1'b0;
      x_q      <= '0;
    end else begin
      state_q  <= state_d;
      line_q   <= line_d;
      pos_q    <= pos_d;
      step_q   <= step_d;
      active_q <= active_d;
      x_q      <= x_d;
    end
  end

  scaler_v_linebuf #(
    .DEPTH (LINE_SIZE_MAX),
    .WIDTH (PIXEL_WIDTH),
    .ADDR_W(ADDR_W)
  ) u_linebuf (
    .clk    (clk),
    .we_i   (pix_ok),
    .waddr_i(x_eff[ADDR_W-1:0]),
    .wdata_i(di_i),
    .raddr_i(x_eff[ADDR_W-1:0]),
    .rdata_o(prev_c)
  );

  // Stages: read, prev product, cur product, add+round, output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de_q   <= '0;
      hs_q   <= '0;
      vs_q   <= '1;
      cur1_q <= '0;
      coe1_q <= '0;
      cur2_q <= '0;
      coe2_q <= '0;
      mp2_q  <= '0;
      mp3_q  <= '0;
      mc3_q  <= '0;
      sum4_q <= '0;
      do_o   <= '0;
      de_o   <= 1'b0;
      hs_o   <= 1'b0;
      vs_o   <= 1'b1;
    end else begin
      de_q   <= {de_q[LAT-2:0], pix_ok && active_d};
      hs_q   <= {hs_q[LAT-2:0], hs_i && active_d};
      vs_q   <= {vs_q[LAT-2:0], vs_i};
      cur1_q <= di_i;
      coe1_q <= coe_c;
      cur2_q <= cur1_q;
      coe2_q <= coe1_q;
      mp2_q  <= PROD_W'(prev_c) * ((PROD_W'(1) << COE_WIDTH) - PROD_W'(coe1_q));
      mp3_q  <= mp2_q;
      mc3_q  <= PROD_W'(cur2_q) * PROD_W'(coe2_q);
      sum4_q <= mp3_q + mc3_q + (PROD_W'(1) << (COE_WIDTH - 1));
      do_o   <= PIXEL_WIDTH'(sum4_q >> COE_WIDTH);
      de_o   <= de_q[LAT-1];
      hs_o   <= hs_q[LAT-1];
      vs_o   <= vs_q[LAT-1];
    end
  end

endmodule

// File: tb/tb_scaler_v.sv
// Self-checking bench for scaler_v: frame-level reference model with a
// cycle-indexed expectation ring compared every clock.
module tb_scaler_v;

  localparam int PS   = 32;
  localparam int LMAX = 4096;
  localparam int MAXW = 4100;
  localparam int RING = 16;
  localparam int BIG  = 1 << 30;

  logic        clk;
  logic        rst;
  logic [15:0] scale_step_v;
  logic [7:0]  di_i;
  logic        de_i, hs_i, vs_i;
  logic [7:0]  do_o;
  logic        de_o, hs_o, vs_o;

  scaler_v dut (
    .clk         (clk),
    .rst         (rst),
    .scale_step_v(scale_step_v),
    .di_i        (di_i),
    .de_i        (de_i),
    .hs_i        (hs_i),
    .vs_i        (vs_i),
    .do_o        (do_o),
    .de_o        (de_o),
    .hs_o        (hs_o),
    .vs_o        (vs_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         errs, checks, edge_n, step_eff;
  logic       r_de [RING];
  logic       r_hs [RING];
  logic       r_vs [RING];
  logic [7:0] r_do [RING];
  logic [7:0] img  [8][MAXW];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, ".do_o"}, 32'(do_o), 32'd0);
    check_eq({tag, ".de_o"}, 32'(de_o), 32'd0);
    check_eq({tag, ".hs_o"}, 32'(hs_o), 32'd0);
    check_eq({tag, ".vs_o"}, 32'(vs_o), 32'd1);
  endtask

  task automatic ring_idle();
    for (int i = 0; i < RING; i++) begin
      r_de[i] = 1'b0; r_hs[i] = 1'b0; r_vs[i] = 1'b1; r_do[i] = 8'd0;
    end
  endtask

  // Linear blend with weight frac/PS towards the current line, rounded half up.
  function automatic logic [7:0] blend(input int p, input int c, input int frac);
    int coe;
    coe = frac * (256 / PS);
    return 8'((p * (256 - coe) + c * coe + 128) / 256);
  endfunction

  // One clock: drive inputs, book what must appear 4 edges after the sampling edge, check outputs.
  task automatic tick(input logic vs, input logic hs, input logic de, input logic [7:0] di,
                      input logic ede, input logic ehs, input logic [7:0] edo);
    int s;
    vs_i = vs; hs_i = hs; de_i = de; di_i = di;
    s = (edge_n + 1 + 4) % RING;
    r_de[s] = ede; r_hs[s] = ehs; r_vs[s] = rst ? 1'b1 : vs; r_do[s] = edo;
    @(posedge clk);
    edge_n++;
    @(negedge clk);
    s = edge_n % RING;
    check_eq("de_o", 32'(de_o), 32'(r_de[s]));
    check_eq("hs_o", 32'(hs_o), 32'(r_hs[s]));
    check_eq("vs_o", 32'(vs_o), 32'(r_vs[s]));
    if (r_de[s]) check_eq("do_o", 32'(do_o), 32'(r_do[s]));
  endtask

  task automatic drive_line(input int n, input int w, input int mode, input int pat,
                            input bit coinc, input int vs_at, input bit en);
    bit         act, hs, vsv;
    int         frac, gap;
    logic [7:0] pix, e;
    act = 1'b0; frac = 0;
    if (en && n >= 1)
      for (int m = 0; (m * step_eff) / PS <= n - 1; m++)
        if ((m * step_eff) / PS == n - 1) begin
          act  = 1'b1;
          frac = (m * step_eff) % PS;
        end
    if (!coinc) tick(vs_at <= 0, 1'b1, 1'b0, 8'd0, 1'b0, act && (vs_at > 0), 8'd0);
    for (int x = 0; x < w; x++) begin
      vsv = (x >= vs_at);
      hs  = coinc && (x == 0);
      case (pat)
        0:       pix = 8'(x + 16 * n);
        1:       pix = 8'(16 * n);
        default: pix = 8'($urandom);
      endcase
      img[n][x] = pix;
      gap = (mode == 1) ? 3 : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
      if (x > 0) repeat (gap) tick(vsv, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0);
      e = (act && x < LMAX) ? blend(int'(img[n-1][x]), int'(pix), frac) : 8'd0;
      tick(vsv, hs, 1'b1, pix, act && !vsv && (x < LMAX), hs && act && !vsv, e);
    end
    repeat (2) tick(vs_at <= w, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0);
  endtask

  task automatic blank(input int step);
    scale_step_v = 16'(step);
    repeat (4) tick(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0);
    step_eff = (step < PS) ? PS : step;
  endtask

  task automatic drive_frame(input int step, input int h, input int w, input int mode,
                             input int pat, input bit rcoinc, input int step_mid);
    blank(step);
    for (int n = 0; n < h; n++) begin
      if (n == h / 2) scale_step_v = 16'(step_mid);
      drive_line(n, w, mode, pat, rcoinc ? bit'($urandom_range(0, 1)) : 1'b0, BIG, 1'b1);
    end
  endtask

  initial begin
    int st;
    errs = 0; checks = 0; edge_n = 0; step_eff = PS;
    rst = 1'b1; vs_i = 1'b1; hs_i = 1'b0; de_i = 1'b0; di_i = 8'd0; scale_step_v = 16'd32;
    ring_idle();
    #2;
    check_reset("reset");
    repeat (3) tick(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0);
    rst = 1'b0;

    drive_frame(32, 8, 8, 0, 0, 1'b0, 32);   // unity step
    drive_frame(64, 8, 8, 0, 0, 1'b0, 64);   // 2:1
    drive_frame(48, 8, 8, 0, 1, 1'b0, 48);   // 1.5:1 on flat lines
    drive_frame(32, 8, 8, 1, 0, 1'b0, 32);   // sparse de_i
    drive_frame(16, 8, 8, 0, 0, 1'b0, 16);   // clamped step
    drive_frame(16, 8, 8, 0, 0, 1'b0, 64);   // step change mid-frame is ignored

    // Reset in the middle of line 3; the rest of that frame must be ignored.
    blank(32);
    for (int n = 0; n < 3; n++) drive_line(n, 8, 0, 0, 1'b0, BIG, 1'b1);
    drive_line(3, 4, 0, 0, 1'b0, BIG, 1'b1);
    rst = 1'b1;
    #1;
    check_reset("rst_mid_line");
    ring_idle();
    repeat (3) tick(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0);
    rst = 1'b0;
    drive_line(4, 8, 0, 0, 1'b0, BIG, 1'b0);
    drive_line(5, 8, 0, 0, 1'b0, BIG, 1'b0);

    // vs_i rises mid-line 4, then a whole line arrives during blanking.
    blank(32);
    for (int n = 0; n < 4; n++) drive_line(n, 8, 0, 0, 1'b0, BIG, 1'b1);
    drive_line(4, 8, 0, 0, 1'b0, 4, 1'b1);
    drive_line(5, 8, 0, 0, 1'b0, 0, 1'b1);
    drive_frame(32, 8, 8, 0, 0, 1'b0, 32);

    // Random steps, widths, gaps and hs/de coincidence.
    repeat (5) begin
      st = int'($urandom_range(16, 100));
      drive_frame(st, 8, int'($urandom_range(3, 12)), 2, 2, 1'b1, st);
    end

    // Lines longer than the buffer: the tail is dropped and must not corrupt it.
    drive_frame(32, 3, MAXW, 0, 2, 1'b0, 32);
    repeat (8) tick(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
